// File: rtl/uart_tx_queue.sv
// uart_tx_queue: FIFO feeder that hands queued words to the UART transmitter one packet at a time.
// Define UART_TXQ_TIMEOUT_EN to bound the wait for busy in REQ and expose the sticky timeout_err flag.
module uart_tx_queue #(
  parameter int PACKET_SIZE = 16,
  parameter int DEPTH       = 8,
  parameter int GAP_CYCLES  = 200,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PACKET_SIZE-1:0]       wr_data,
  input  logic                         wr_en,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [PACKET_SIZE-1:0]       tx_data,
  output logic                         tx_send,
  input  logic                         tx_busy,
  output logic [15:0]                  sent_cnt
`ifdef UART_TXQ_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, BUSY, GAP} stateT;

  stateT                  state, stateNext;
  logic [PACKET_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]          wrPtr, rdPtr;
  logic [CW-1:0]          countNext;
  logic [GW-1:0]          gapCnt;
  logic                   doPush, doPop, ackExpired;

  // LOAD is only reached from IDLE with a non-empty queue, so the pop never underflows
  assign doPop  = (state == LOAD);
  assign doPush = wr_en && (!full || doPop);

  always_comb begin
    countNext = count;
    if (doPush && !doPop)
      countNext = count + 1'b1;
    else if (doPop && !doPush)
      countNext = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (doPush)
      mem[wrPtr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (doPush)
        wrPtr <= wrPtr + 1'b1;
      if (doPop)
        rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      empty <= (countNext == '0);
      full  <= (countNext == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (!empty) stateNext = LOAD;
      LOAD: stateNext = REQ;
      REQ: begin
        if (tx_busy)
          stateNext = BUSY;
        else if (ackExpired)
          stateNext = GAP;
      end
      BUSY: if (!tx_busy) stateNext = GAP;
      // counter reaches zero on the exit edge, leaving GAP_CYCLES-1 cycles in GAP
      GAP: if (gapCnt <= GW'(1)) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= '0;
      tx_send  <= 1'b0;
      sent_cnt <= '0;
      gapCnt   <= '0;
    end else begin
      tx_send <= (stateNext == REQ);
      if (doPop)
        tx_data <= mem[rdPtr];
      if (state == BUSY && !tx_busy)
        sent_cnt <= sent_cnt + 16'd1;
      if (state != GAP && stateNext == GAP)
        gapCnt <= GW'(GAP_CYCLES - 1);
      else if (state == GAP && gapCnt != '0)
        gapCnt <= gapCnt - 1'b1;
    end
  end

`ifdef UART_TXQ_TIMEOUT_EN
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [AW-1:0] ackCnt;

  assign ackExpired = (ackCnt == AW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ackCnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == LOAD)
        ackCnt <= '0;
      else if (state == REQ)
        ackCnt <= ackCnt + 1'b1;
      if (state == REQ && !tx_busy && ackExpired)
        timeout_err <= 1'b1;
    end
  end
`else
  assign ackExpired = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue; builds with or without UART_TXQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_uart_tx_queue;
  localparam int PS    = 16;
  localparam int DEPTH = 8;
  localparam int GAP   = 200;
`ifdef UART_TXQ_TIMEOUT_EN
  localparam int ACKTO = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int ACKTO = 4096;
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic [PS-1:0] wr_data = '0;
  logic          wr_en   = 1'b0;
  logic          tx_busy = 1'b0;
  logic          full, empty, tx_send;
  logic [3:0]    count;
  logic [PS-1:0] tx_data;
  logic [15:0]   sent_cnt;
`ifdef UART_TXQ_TIMEOUT_EN
  logic          timeout_err;
`endif

  uart_tx_queue #(
    .PACKET_SIZE(PS), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACKTO)
  ) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .sent_cnt(sent_cnt)
`ifdef UART_TXQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, got, want);
    end
  endtask

  // Reference: a word queue plus timestamps for when the dispatcher may look at the queue again.
  logic [PS-1:0] mq[$];
  logic [PS-1:0] mData;
  logic          mSend, mErr;
  logic [15:0]   mSent;
  int            idleFrom, popAt, reqStart;
  bit            awaitAck, awaitDone;

  always @(posedge clk) begin
    int c, sz;
    bit pop, idleNow;
    c   = cyc;
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      mData = '0; mSend = 1'b0; mSent = '0; mErr = 1'b0;
      idleFrom = 0; popAt = -1; reqStart = 0;
      awaitAck = 1'b0; awaitDone = 1'b0;
    end else begin
      sz      = mq.size();
      idleNow = !awaitAck && !awaitDone && (popAt < 0) && (c >= idleFrom);
      pop     = (popAt == c);
      if (pop) begin
        mData = mq.pop_front();
        mSend = 1'b1; awaitAck = 1'b1; reqStart = c + 1; popAt = -1;
      end else if (awaitAck) begin
        if (tx_busy) begin
          mSend = 1'b0; awaitAck = 1'b0; awaitDone = 1'b1;
        end else if (TO_EN && (c - reqStart + 1 >= ACKTO)) begin
          mSend = 1'b0; awaitAck = 1'b0; mErr = 1'b1; idleFrom = c + GAP;
        end
      end else if (awaitDone && !tx_busy) begin
        awaitDone = 1'b0; mSent = mSent + 16'd1; idleFrom = c + GAP;
      end
      // the queue is noticed in an idle cycle, popped one cycle later, requested the cycle after
      if (idleNow && sz > 0)
        popAt = c + 1;
      if (wr_en && mq.size() < DEPTH)
        mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_tx_send", tx_send, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_sent_cnt", sent_cnt, 0);
    end else begin
      chk("cmp_count", count, mq.size());
      chk("cmp_empty", empty, mq.size() == 0);
      chk("cmp_full", full, mq.size() == DEPTH);
      chk("cmp_tx_data", tx_data, mData);
      chk("cmp_tx_send", tx_send, mSend);
      chk("cmp_sent_cnt", sent_cnt, mSent);
`ifdef UART_TXQ_TIMEOUT_EN
      chk("cmp_timeout_err", timeout_err, mErr);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PS-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  // Plays the transmitter for one packet: busy rises the cycle after the request is seen.
  task automatic serve(input logic [PS-1:0] want, input int len, input int lastFall,
                       output int riseCyc, output int fallCyc);
    int k = 0;
    while (tx_send !== 1'b1 && k < 2000) begin
      tick(1);
      k++;
    end
    riseCyc = cyc;
    chk("req_wait", k < 2000, 1);
    chk("req_data", tx_data, want);
    if (lastFall >= 0)
      chk("req_spacing", riseCyc - lastFall, GAP + 2);
    tick(1);
    tx_busy = 1'b1;
    tick(1);
    chk("send_drop", tx_send, 0);
    tick(len - 1);
    tx_busy = 1'b0;
    fallCyc = cyc;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int w, r, f, fPrev, n;
    tick(3);
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_tx_send", tx_send, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_sent_cnt", sent_cnt, 0);
    rst = 1'b0;
    tick(2);

    // single word with a realistic transmitter busy time
    w = cyc;
    push(16'hA5C3);
    serve(16'hA5C3, 1700, -1, r, f);
    chk("first_latency", r - w, 3);
    tick(2);
    chk("first_sent_cnt", sent_cnt, 1);
    chk("first_empty", empty, 1);

    // burst during the gap: fills the queue, ninth write dropped
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = PS'(i);
      tick(1);
    end
    chk("burst_full", full, 1);
    wr_data = 16'hFFFF;
    tick(1);
    wr_en = 1'b0;
    chk("drop_count", count, 8);

    // write on the LOAD cycle of a full queue
    while (cyc < f + GAP + 1) tick(1);
    push(16'h1234);
    chk("pushpop_count", count, 8);
    chk("pushpop_full", full, 1);

    fPrev = f;
    for (int i = 1; i <= 8; i++) begin
      serve(PS'(i), 30, fPrev, r, f);
      fPrev = f;
    end
    serve(16'h1234, 30, fPrev, r, f);
    tick(3);
    chk("burst_sent_cnt", sent_cnt, 10);
    chk("burst_empty", empty, 1);

    // transmitter already busy when the request goes out
    tick(GAP + 5);
    tx_busy = 1'b1;
    tick(2);
    push(16'h5A5A);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_send) n++;
      tick(1);
    end
    chk("prebusy_send_cycles", n, 1);
    chk("prebusy_data", tx_data, 16'h5A5A);
    tx_busy = 1'b0;
    tick(3);
    chk("prebusy_sent_cnt", sent_cnt, 11);

    // reset while a packet is in flight and three words wait
    tick(GAP + 5);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = PS'(32'hC000 + i);
      tick(1);
    end
    wr_en = 1'b0;
    n = 0;
    while (tx_send !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    chk("mid_req_seen", tx_send, 1);
    tick(1);
    tx_busy = 1'b1;
    tick(3);
    chk("mid_busy_count", count, 3);
    rst = 1'b1;
    #1;
    chk("midrst_tx_send", tx_send, 0);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_full", full, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_sent_cnt", sent_cnt, 0);
    tick(2);
    rst = 1'b0;
    tx_busy = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (tx_send) n++;
    end
    chk("post_reset_sends", n, 0);
    chk("post_reset_count", count, 0);

`ifdef UART_TXQ_TIMEOUT_EN
    // no acknowledge: request times out, word dropped, next word still goes out
    push(16'h00FF);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_send) n++;
      tick(1);
    end
    chk("to_send_cycles", n, ACKTO);
    chk("to_err", timeout_err, 1);
    chk("to_sent_cnt", sent_cnt, 0);
    push(16'h0100);
    serve(16'h0100, 20, -1, r, f);
    tick(3);
    chk("to_next_sent_cnt", sent_cnt, 1);
    chk("to_err_sticky", timeout_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
